// File: rtl/iob_ila_stream_packer.sv
// iob_ila_stream_packer
//   Packs RATIO consecutive DATA_W-bit sample beats into one wide word,
//   buffers packed words in a first-word-fall-through FIFO and emits them
//   as bursts of up to BURST_LEN words with a last flag. A flush request
//   closes a partial word (unused lanes zero-filled) and the current burst.
// Ports:
//   clk_i, rst_n_i    clock, synchronous active-low reset
//   cke_i             clock enable, freezes all state when low
//   s_tdata_i/s_tvalid_i/s_tready_o  sample beat input stream
//   flush_i           single-cycle request to close the word and burst
//   m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o  packed word output stream
//   level_o           number of words held in the FIFO
module iob_ila_stream_packer #(
    parameter int DATA_W      = 32,
    parameter int RATIO       = 2,
    parameter int FIFO_ADDR_W = 4,
    parameter int BURST_LEN   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cke_i,
    input  logic [DATA_W-1:0]         s_tdata_i,
    input  logic                      s_tvalid_i,
    output logic                      s_tready_o,
    input  logic                      flush_i,
    output logic [RATIO*DATA_W-1:0]   m_tdata_o,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      m_tlast_o,
    output logic [FIFO_ADDR_W:0]      level_o
);

    localparam int LANE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int BURST_W = $clog2(BURST_LEN);
    localparam int WORD_W  = RATIO * DATA_W;
    localparam int DEPTH   = 1 << FIFO_ADDR_W;
    localparam int PTR_W   = FIFO_ADDR_W + 1;

    localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(RATIO - 1);
    localparam logic [BURST_W-1:0] LAST_BEAT  = BURST_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0]   FULL_LEVEL = PTR_W'(DEPTH);

    logic [LANE_W-1:0]  lane_q, lane_d;
    logic               flush_pend_q, flush_pend_d;
    logic [DATA_W-1:0]  asm_q [RATIO];
    logic [WORD_W:0]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [BURST_W-1:0] burst_q;

    logic              full, empty;
    logic              accept, word_done, pad_push, push, push_last, pop;
    logic              flush_start;
    logic [WORD_W-1:0] push_word;
    logic [WORD_W:0]   head;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full    = (level_o == FULL_LEVEL);
    assign empty   = (level_o == '0);

    // Only the beat that completes a word needs a free FIFO slot.
    assign s_tready_o = rst_n_i & ~flush_pend_q & ((lane_q != LAST_LANE) | ~full);

    assign accept    = s_tvalid_i & s_tready_o & cke_i;
    assign word_done = accept & (lane_q == LAST_LANE);
    // Ready is low while a flush is pending, so pad_push never meets accept.
    assign pad_push  = flush_pend_q & ~full & cke_i;
    assign push      = word_done | pad_push;
    assign push_last = flush_pend_q | flush_i;
    assign pop       = m_tvalid_o & m_tready_i & cke_i;

    // A flush arms only when a partial word will remain after this cycle.
    assign flush_start = cke_i & flush_i & ~flush_pend_q & ~word_done &
                         (accept | (lane_q != '0));

    always_comb begin
        lane_d       = lane_q;
        flush_pend_d = flush_pend_q;
        if (pad_push) begin
            lane_d       = '0;
            flush_pend_d = 1'b0;
        end else if (word_done) begin
            lane_d = '0;
        end else begin
            if (accept) begin
                lane_d = lane_q + 1'b1;
            end
            if (flush_start) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    // Lanes below lane_q come from the assembly register, the lane being
    // written this cycle comes straight from the input, the rest read zero.
    always_comb begin
        push_word = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (i < 32'(lane_q)) begin
                push_word[i*DATA_W +: DATA_W] = asm_q[i];
            end else if ((i == 32'(lane_q)) && accept) begin
                push_word[i*DATA_W +: DATA_W] = s_tdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lane_q       <= '0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            burst_q      <= '0;
        end else if (cke_i) begin
            lane_q       <= lane_d;
            flush_pend_q <= flush_pend_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                burst_q  <= m_tlast_o ? '0 : burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && cke_i) begin
            if (accept) begin
                asm_q[lane_q] <= s_tdata_i;
            end
            if (push) begin
                mem[wr_ptr_q[FIFO_ADDR_W-1:0]] <= {push_last, push_word};
            end
        end
    end

    assign head       = mem[rd_ptr_q[FIFO_ADDR_W-1:0]];
    assign m_tvalid_o = ~empty;
    assign m_tdata_o  = m_tvalid_o ? head[WORD_W-1:0] : '0;
    assign m_tlast_o  = m_tvalid_o & (head[WORD_W] | (burst_q == LAST_BEAT));

endmodule

// File: tb/tb_iob_ila_stream_packer.sv
// tb_iob_ila_stream_packer
//   Directed bench for iob_ila_stream_packer (DATA_W=32, RATIO=2,
//   FIFO_ADDR_W=4, BURST_LEN=16). Expected packed words are queued when the
//   corresponding beats/flushes are accepted and checked as words leave.
module tb_iob_ila_stream_packer;

    logic        clk;
    logic        rst_n;
    logic        cke;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        flush;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [4:0]  level;

    int total = 0;
    int bad   = 0;

    // Reference state: queued words {last, data}, lane, lane-0 beat, burst count.
    logic [64:0] sb [$];
    int          m_lane  = 0;
    logic [31:0] m_asm0  = '0;
    int          m_burst = 0;

    iob_ila_stream_packer #(
        .DATA_W     (32),
        .RATIO      (2),
        .FIFO_ADDR_W(4),
        .BURST_LEN  (16)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .cke_i     (cke),
        .s_tdata_i (s_tdata),
        .s_tvalid_i(s_tvalid),
        .s_tready_o(s_tready),
        .flush_i   (flush),
        .m_tdata_o (m_tdata),
        .m_tvalid_o(m_tvalid),
        .m_tready_i(m_tready),
        .m_tlast_o (m_tlast),
        .level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, update the
    // reference, then advance to 1 time unit after the rising edge.
    task automatic tick(output bit acc);
        logic [64:0] e;
        logic        el;
        #1;
        acc = s_tvalid && s_tready && cke && rst_n;
        if (m_tvalid && m_tready && cke && rst_n) begin
            if (sb.size() == 0) begin
                chk("extra_word", 65'(m_tvalid), 65'd0);
            end else begin
                e  = sb.pop_front();
                el = e[64] | (m_burst == 15);
                chk("word_data", 65'(m_tdata), 65'(e[63:0]));
                chk("word_last", 65'(m_tlast), 65'(el));
                m_burst = el ? 0 : m_burst + 1;
            end
        end
        if (acc) begin
            if (m_lane == 0) begin
                m_asm0 = s_tdata;
                if (flush) sb.push_back({1'b1, 32'h0, s_tdata});
                else       m_lane = 1;
            end else begin
                sb.push_back({flush, s_tdata, m_asm0});
                m_lane = 0;
            end
        end else if (flush && cke && rst_n && m_lane == 1) begin
            sb.push_back({1'b1, 32'h0, m_asm0});
            m_lane = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) tick(acc);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic fl);
        bit acc;
        bit got;
        got      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        flush    = fl;
        for (int k = 0; k < 200 && !got; k++) begin
            tick(acc);
            got = acc;
        end
        s_tvalid = 1'b0;
        flush    = 1'b0;
        chk("beat_accept", 65'(got), 65'd1);
    endtask

    task automatic drain();
        bit acc;
        m_tready = 1'b1;
        for (int k = 0; k < 300 && sb.size() > 0; k++) tick(acc);
        chk("drain_left", 65'(sb.size()), 65'd0);
        idle(3);
        chk("drain_idle_valid", 65'(m_tvalid), 65'd0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        flush    = 1'b0;
        idle(1);
        sb.delete();
        m_lane  = 0;
        m_burst = 0;
    endtask

    initial begin
        bit acc;
        rst_n    = 1'b0;
        cke      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        flush    = 1'b0;
        m_tready = 1'b0;

        // Reset state
        do_reset();
        idle(1);
        chk("rst_valid", 65'(m_tvalid), 65'd0);
        chk("rst_last",  65'(m_tlast),  65'd0);
        chk("rst_data",  65'(m_tdata),  65'd0);
        chk("rst_level", 65'(level),    65'd0);
        chk("rst_ready", 65'(s_tready), 65'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 65'(s_tready), 65'd1);

        // Continuous stream 0x1..0x20, last only on the 16th word
        m_tready = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            send_beat(32'(k), 1'b0);
            if (k == 2) begin
                chk("first_word_valid", 65'(m_tvalid), 65'd1);
                chk("first_word_data",  65'(m_tdata),  65'h0000_0002_0000_0001);
            end
        end
        drain();

        // Backpressure: 33 beats fill the FIFO and one lane
        m_tready = 1'b0;
        for (int k = 1; k <= 33; k++) send_beat(32'(k), 1'b0);
        chk("bp_level", 65'(level),    65'd16);
        chk("bp_ready", 65'(s_tready), 65'd0);
        s_tvalid = 1'b1;
        s_tdata  = 32'h22;
        for (int k = 0; k < 5; k++) begin
            tick(acc);
            chk("bp_no_accept", 65'(acc),     65'd0);
            chk("bp_hold_data", 65'(m_tdata), 65'h0000_0002_0000_0001);
            chk("bp_hold_last", 65'(m_tlast), 65'd0);
        end
        m_tready = 1'b1;
        send_beat(32'h22, 1'b0);
        drain();

        // Three beats then flush: one full word, one padded last word
        m_tready = 1'b0;
        send_beat(32'hA, 1'b0);
        send_beat(32'hB, 1'b0);
        send_beat(32'hC, 1'b0);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(1);
        chk("flush_level", 65'(level), 65'd2);
        drain();

        // Burst count restarts after the flush; cke pauses mid-stream
        m_tready = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 10) begin
                s_tvalid = 1'b1;
                s_tdata  = 32'(k);
                cke      = 1'b0;
                idle(3);
                cke = 1'b1;
                chk("cke_ready", 65'(s_tready), 65'd1);
            end
            send_beat(32'(k) + 32'h40, 1'b0);
        end
        drain();

        // Flush with the word-completing beat: single word, no padding
        m_tready = 1'b0;
        send_beat(32'hD, 1'b0);
        send_beat(32'hE, 1'b1);
        idle(1);
        chk("flush2_level", 65'(level), 65'd1);
        drain();

        // Flush with an empty assembly register: no output
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(3);
        chk("flush0_valid", 65'(m_tvalid), 65'd0);
        chk("flush0_level", 65'(level),    65'd0);
        chk("flush0_ready", 65'(s_tready), 65'd1);

        // Flush while FIFO full with one lane pending
        m_tready = 1'b0;
        for (int k = 1; k <= 33; k++) send_beat(32'h100 + 32'(k), 1'b0);
        chk("ff_level", 65'(level), 65'd16);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("ff_ready_low", 65'(s_tready), 65'd0);
            chk("ff_level_hold", 65'(level),   65'd16);
        end
        drain();
        chk("ff_ready_back", 65'(s_tready), 65'd1);

        // Reset mid-burst discards buffered words
        m_tready = 1'b0;
        for (int k = 1; k <= 10; k++) send_beat(32'h200 + 32'(k), 1'b0);
        chk("mid_level", 65'(level), 65'd5);
        do_reset();
        chk("mid_rst_level", 65'(level),    65'd0);
        chk("mid_rst_valid", 65'(m_tvalid), 65'd0);
        chk("mid_rst_last",  65'(m_tlast),  65'd0);
        chk("mid_rst_ready", 65'(s_tready), 65'd0);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        idle(3);
        chk("post_rst_valid", 65'(m_tvalid), 65'd0);
        send_beat(32'h55, 1'b0);
        send_beat(32'h66, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
